serial_flag_adder: RTL and testbench
====================================

Name: serial_flag_adder

Overview:
- Multi-cycle signed adder/subtractor that processes operands DIGIT_BITS per clock, LSB-first, through a carry-chained digit slice.
- Produces a registered sum and the N/Z/P status flags, extended with carry (C) and signed overflow (V).
- Ready/valid handshake on input and output. Used where area matters more than latency; a parametrised successor to the team's combinational flag adder.

Parameters:
- N_BITS, 8, operand and result width in bits (>=2).
- DIGIT_BITS, 1, bits added per cycle; must divide N_BITS exactly (elaboration-time assertion).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operation request.
- start_ready  output  1  block can accept a request.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled at acceptance.
- a  input  N_BITS  signed operand A; sampled at acceptance.
- b  input  N_BITS  signed operand B; sampled at acceptance.
- result_valid  output  1  s and flags hold a completed result.
- result_ready  input  1  consumer accepts the result.
- s  output  N_BITS  signed sum/difference, wraps modulo 2^N_BITS.
- n  output  1  negative: s[N_BITS-1].
- z  output  1  zero: s == 0.
- p  output  1  even: s[0] == 0.
- c  output  1  carry out of MSB (for subtract, 1 = no borrow).
- v  output  1  signed overflow.

Behaviour:
- Reset: clock and reset_n as stated, with an asynchronous, active-low reset. Reset returns the FSM to IDLE and clears s, n, z, p, c, v, result_valid and all internal registers to 0. Reset mid-operation abandons the operation, and no result is produced.
- FSM states: IDLE, BUSY, DONE.
- start_ready = (state == IDLE), decoded combinationally from the state register. It reads 1 while reset is held.
- IDLE:
  - On start_valid && start_ready: latch a into an operand shift register and latch b (or ~b if op_sub) into a second one.
  - Carry register <= op_sub; digit counter <= 0; go to BUSY.
- BUSY, each cycle:
  - Add the low DIGIT_BITS of both shift registers plus the carry register.
  - Shift the digit sum into the MSB end of the result shift register; update the carry; shift the operands right by DIGIT_BITS.
  - Increment the counter.
  - After K = N_BITS/DIGIT_BITS digits, go to DONE.
  - a, b, op_sub and start_valid are ignored while BUSY.
- Completion edge (the last BUSY cycle):
  - s <= assembled result; c <= final carry.
  - v <= (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the possibly-inverted operand.
  - n, z, p are computed from the completed sum, and all outputs are registered.
- Latency: result_valid rises exactly K cycles after the acceptance edge (8 cycles for the defaults).
- DONE:
  - result_valid = 1; s and flags are stable.
  - On result_ready, go to IDLE at the next edge, where result_valid drops.
  - start_valid is not accepted in DONE; there is no back-to-back bypass.
  - result_ready is ignored outside DONE.
- After handoff, s and the flags hold their last values until the next completion edge.
- Arithmetic: two's complement wrap; no saturation. Subtract is A + ~B + 1.

Decomposition:
- Package serial_flag_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  - localparams OP_ADD = 1'b0 and OP_SUB = 1'b1.
- One sub-module, digit_adder (parameter DIGIT_BITS): a combinational ripple adder with inputs x, y and cin, and outputs sum and cout. It is instantiated once, and the top owns all state.

Test Plan:
1. Add 5+3 (N=8, D=1): s=8, n0 z0 p1 c0 v0; result_valid asserted exactly 8 cycles after acceptance.
2. Add 127+1: s=0x80 (-128), n1 z0 p1 c0 v1.
3. Sub 3-3: s=0, z1 p1 c1 v0 n0.
4. Sub 0-(-128): s=0x80, n1 c0 v1. Then sub -128-1: s=0x7F, v1 c1 n0 p0.
5. Backpressure: hold result_ready=0 for 20 cycles in DONE while pulsing start_valid with new operands. Required response:
   - result_valid=1 and start_ready=0 throughout.
   - s and flags unchanged; no acceptance.
   - After result_ready=1 for one cycle: IDLE, start_ready=1, result_valid=0.
6. Reset and D=4:
   - Assert reset_n=0 at BUSY cycle 4 of an add: all outputs 0 immediately, state IDLE.
   - Re-instantiate with D=4 and add -1 + -1: s=0xFE, n1 c1 p1 v0 z0, result_valid after 2 cycles.

Source files
------------

// File: rtl/serial_flag_adder_pkg.sv
// Shared types and constants for the digit-serial flag adder.
package serial_flag_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_flag_adder_digit.sv
// One digit slice of the serial adder: DIGIT_BITS-wide add with carry in/out.
module digit_adder #(
  parameter int DIGIT_BITS = 1
) (
  input  logic [DIGIT_BITS-1:0] x,
  input  logic [DIGIT_BITS-1:0] y,
  input  logic                  cin,
  output logic [DIGIT_BITS-1:0] sum,
  output logic                  cout
);

  logic [DIGIT_BITS:0] total_s;

  // Combinational digit add; the MSB of the widened total is the carry out.
  always_comb begin
    total_s = {1'b0, x} + {1'b0, y} + {{DIGIT_BITS{1'b0}}, cin};
    sum     = total_s[DIGIT_BITS-1:0];
    cout    = total_s[DIGIT_BITS];
  end

endmodule

// File: rtl/serial_flag_adder.sv
// Digit-serial signed adder/subtractor with registered sum and N/Z/P/C/V flags.
module serial_flag_adder
  import serial_flag_adder_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int DIGIT_BITS = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              op_sub,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [N_BITS-1:0] s,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic              c,
  output logic              v
);

  localparam int K     = N_BITS / DIGIT_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  if ((N_BITS < 2) || ((N_BITS % DIGIT_BITS) != 0)) begin : g_param_err
    $error("serial_flag_adder: DIGIT_BITS must divide N_BITS and N_BITS must be >= 2");
  end

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   a_sh_q, a_sh_d;
  logic [N_BITS-1:0]   b_sh_q, b_sh_d;
  logic [N_BITS-1:0]   res_sh_q, res_sh_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   s_q, s_d;
  logic                n_q, n_d, z_q, z_d, p_q, p_d, c_q, c_d, v_q, v_d;
  logic                result_valid_q, result_valid_d;

  logic [DIGIT_BITS-1:0] dig_sum_s;
  logic                  dig_cout_s;
  logic [N_BITS-1:0]     res_next_s;
  logic                  last_digit_s;

  digit_adder #(.DIGIT_BITS(DIGIT_BITS)) u_digit (
    .x    (a_sh_q[DIGIT_BITS-1:0]),
    .y    (b_sh_q[DIGIT_BITS-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum_s),
    .cout (dig_cout_s)
  );

  // New digit enters at the MSB end; works even when one digit spans the word.
  assign res_next_s   = N_BITS'({dig_sum_s, res_sh_q} >> DIGIT_BITS);
  assign last_digit_s = (cnt_q == CNT_W'(K - 1));

  // Next-state, datapath and flag computation.
  always_comb begin
    state_d        = state_q;
    a_sh_d         = a_sh_q;
    b_sh_d         = b_sh_q;
    res_sh_d       = res_sh_q;
    carry_d        = carry_q;
    cnt_d          = cnt_q;
    s_d            = s_q;
    n_d            = n_q;
    z_d            = z_q;
    p_d            = p_q;
    c_d            = c_q;
    v_d            = v_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = (op_sub == OP_ADD) ? b : ~b;
          carry_d = (op_sub == OP_SUB);
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        a_sh_d   = a_sh_q >> DIGIT_BITS;
        b_sh_d   = b_sh_q >> DIGIT_BITS;
        res_sh_d = res_next_s;
        carry_d  = dig_cout_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_digit_s) begin
          // The operand MSBs sit at the top of the final digit.
          s_d            = res_next_s;
          c_d            = dig_cout_s;
          v_d            = (a_sh_q[DIGIT_BITS-1] == b_sh_q[DIGIT_BITS-1]) &&
                           (res_next_s[N_BITS-1] != a_sh_q[DIGIT_BITS-1]);
          n_d            = res_next_s[N_BITS-1];
          z_d            = (res_next_s == '0);
          p_d            = ~res_next_s[0];
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        result_valid_d = 1'b0;
        state_d        = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      res_sh_q       <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      s_q            <= '0;
      n_q            <= 1'b0;
      z_q            <= 1'b0;
      p_q            <= 1'b0;
      c_q            <= 1'b0;
      v_q            <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_sh_q         <= a_sh_d;
      b_sh_q         <= b_sh_d;
      res_sh_q       <= res_sh_d;
      carry_q        <= carry_d;
      cnt_q          <= cnt_d;
      s_q            <= s_d;
      n_q            <= n_d;
      z_q            <= z_d;
      p_q            <= p_d;
      c_q            <= c_d;
      v_q            <= v_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = result_valid_q;
  assign s            = s_q;
  assign n            = n_q;
  assign z            = z_q;
  assign p            = p_q;
  assign c            = c_q;
  assign v            = v_q;

endmodule

// File: tb/tb_serial_flag_adder.sv
// Self-checking bench: a D=1 and a D=4 instance share stimulus and are checked together.
module tb_serial_flag_adder;

  logic       clock;
  logic       reset_n;
  logic       start_valid;
  logic       op_sub;
  logic [7:0] a, b;
  logic       result_ready;

  logic       sr8, rv8, n8, z8, p8, c8, v8;
  logic [7:0] s8;
  logic       sr4, rv4, n4, z4, p4, c4, v4;
  logic [7:0] s4;

  int tests = 0;
  int fails = 0;

  serial_flag_adder #(.N_BITS(8), .DIGIT_BITS(1)) dut8 (
    .clock(clock), .reset_n(reset_n), .start_valid(start_valid), .start_ready(sr8),
    .op_sub(op_sub), .a(a), .b(b), .result_valid(rv8), .result_ready(result_ready),
    .s(s8), .n(n8), .z(z8), .p(p8), .c(c8), .v(v8)
  );

  serial_flag_adder #(.N_BITS(8), .DIGIT_BITS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start_valid(start_valid), .start_ready(sr4),
    .op_sub(op_sub), .a(a), .b(b), .result_valid(rv4), .result_ready(result_ready),
    .s(s4), .n(n4), .z(z4), .p(p4), .c(c4), .v(v4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [4:0] f;  // {n,z,p,c,v}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned values.
  task automatic model(input logic op, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] rs, output logic [4:0] rf);
    int sr;
    int ur;
    logic cf, vf;
    sr = op ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y));
    ur = op ? (int'(x) - int'(y)) : (int'(x) + int'(y));
    rs = 8'(sr);
    vf = (sr > 127) || (sr < -128);
    cf = op ? (ur >= 0) : (ur > 255);
    rf = {rs[7], (rs == 8'h00), ~rs[0], cf, vf};
  endtask

  task automatic check_out(input string tag, input logic [7:0] es, input logic [4:0] ef);
    chk({tag, " s8"}, s8, es);
    chk({tag, " flags8"}, {n8, z8, p8, c8, v8}, ef);
    chk({tag, " s4"}, s4, es);
    chk({tag, " flags4"}, {n4, z4, p4, c4, v4}, ef);
  endtask

  task automatic issue_and_wait(input string tag, input logic o, input logic [7:0] x,
                                input logic [7:0] y);
    int l8, l4;
    @(negedge clock);
    chk({tag, " start_ready8"}, sr8, 1);
    chk({tag, " start_ready4"}, sr4, 1);
    start_valid = 1'b1;
    op_sub      = o;
    a           = x;
    b           = y;
    @(posedge clock);
    @(negedge clock);
    start_valid = 1'b0;
    a           = ~x;
    b           = ~y;
    l8 = 0;
    l4 = 0;
    for (int cyc = 1; cyc <= 40 && (l8 == 0 || l4 == 0); cyc++) begin
      if (cyc > 1) @(posedge clock);
      else @(posedge clock);
      #1;
      if (rv8 && l8 == 0) l8 = cyc;
      if (rv4 && l4 == 0) l4 = cyc;
    end
    chk({tag, " latency8"}, l8, 8);
    chk({tag, " latency4"}, l4, 2);
  endtask

  task automatic release_result(input string tag);
    @(negedge clock);
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, " rv8 drop"}, rv8, 0);
    chk({tag, " rv4 drop"}, rv4, 0);
    chk({tag, " sr8 idle"}, sr8, 1);
    chk({tag, " sr4 idle"}, sr4, 1);
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  vec_t       tbl[7];
  logic [7:0] ms;
  logic [4:0] mf;

  initial begin
    tbl[0] = '{op: 1'b0, a: 8'd5,   b: 8'd3,   s: 8'h08, f: 5'b00100};
    tbl[1] = '{op: 1'b0, a: 8'd127, b: 8'd1,   s: 8'h80, f: 5'b10101};
    tbl[2] = '{op: 1'b1, a: 8'd3,   b: 8'd3,   s: 8'h00, f: 5'b01110};
    tbl[3] = '{op: 1'b1, a: 8'h00,  b: 8'h80,  s: 8'h80, f: 5'b10101};
    tbl[4] = '{op: 1'b1, a: 8'h80,  b: 8'h01,  s: 8'h7F, f: 5'b00011};
    tbl[5] = '{op: 1'b0, a: 8'hFF,  b: 8'hFF,  s: 8'hFE, f: 5'b10110};
    tbl[6] = '{op: 1'b1, a: 8'd100, b: 8'd50,  s: 8'h32, f: 5'b00110};

    reset_n      = 1'b0;
    start_valid  = 1'b0;
    op_sub       = 1'b0;
    a            = 8'h00;
    b            = 8'h00;
    result_ready = 1'b0;
    #2;
    chk("reset sr8", sr8, 1);
    chk("reset rv8", rv8, 0);
    chk("reset s/flags8", {s8, n8, z8, p8, c8, v8}, 0);
    chk("reset s/flags4", {s4, n4, z4, p4, c4, v4, rv4}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      issue_and_wait($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
      check_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].f);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE while new requests are offered.
    issue_and_wait("bp", 1'b1, 8'd100, 8'd50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start_valid = 1'($urandom_range(0, 1));
      op_sub      = 1'($urandom_range(0, 1));
      a           = 8'($urandom);
      b           = 8'($urandom);
      @(posedge clock);
      #1;
      chk("bp rv8", rv8, 1);
      chk("bp sr8", sr8, 0);
      chk("bp rv4", rv4, 1);
      chk("bp sr4", sr4, 0);
      check_out("bp hold", 8'h32, 5'b00110);
    end
    @(negedge clock);
    start_valid = 1'b0;
    release_result("bp");
    repeat (3) @(posedge clock);
    #1;
    chk("bp no accept rv8", rv8, 0);
    chk("bp no accept sr8", sr8, 1);
    check_out("bp after handoff", 8'h32, 5'b00110);

    // Reset in the middle of a D=1 operation.
    @(negedge clock);
    start_valid = 1'b1;
    op_sub      = 1'b0;
    a           = 8'd10;
    b           = 8'd20;
    @(posedge clock);
    @(negedge clock);
    start_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset sr8", sr8, 1);
    chk("midreset rv8", rv8, 0);
    chk("midreset s/flags8", {s8, n8, z8, p8, c8, v8}, 0);
    chk("midreset s/flags4", {s4, n4, z4, p4, c4, v4, rv4}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("midreset no result", {rv8, rv4}, 0);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic       ro;
      logic [7:0] ra, rb;
      ro = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) rb = ra;
      model(ro, ra, rb, ms, mf);
      issue_and_wait($sformatf("rnd%0d", i), ro, ra, rb);
      check_out($sformatf("rnd%0d", i), ms, mf);
      release_result($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
